// File: rtl/dram_arbiter_if.sv
// Signal bundle between dram_arbiter, its CPU and VGA requesters and the DRAM controller.
// The master modport is the arbiter's view; the slave modport is the surrounding system's view.
interface dram_arbiter_if;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_write_en;
    logic [15:0] cpu_data_in;
    logic        cpu_ack;
    logic [15:0] cpu_read_data;

    logic        vga_req;
    logic [8:0]  vga_y_val;
    logic [4:0]  vga_x_group;
    logic        vga_ack;

    logic        dram_refresh_data;
    logic [24:0] dram_addr;
    logic        dram_write_en;
    logic        dram_burst_en;
    logic [15:0] dram_data_in;
    logic [15:0] dram_read_data;
    logic        dram_data_ready;

    logic        timeout_err;

    modport master (
        input  cpu_req, cpu_addr, cpu_write_en, cpu_data_in,
        input  vga_req, vga_y_val, vga_x_group,
        input  dram_read_data, dram_data_ready,
        output cpu_ack, cpu_read_data, vga_ack,
        output dram_refresh_data, dram_addr, dram_write_en, dram_burst_en, dram_data_in,
        output timeout_err
    );

    modport slave (
        output cpu_req, cpu_addr, cpu_write_en, cpu_data_in,
        output vga_req, vga_y_val, vga_x_group,
        output dram_read_data, dram_data_ready,
        input  cpu_ack, cpu_read_data, vga_ack,
        input  dram_refresh_data, dram_addr, dram_write_en, dram_burst_en, dram_data_in,
        input  timeout_err
    );
endinterface

// File: rtl/dram_arbiter.sv
// Two-way arbiter (CPU word port, VGA line burst) in front of a single DRAM controller port.
// One transaction in flight at a time, alternating grants under contention, watchdog per transaction.
module dram_arbiter #(
    parameter int TIMEOUT = 63
) (
    input  logic           clk,
    input  logic           rst,
    dram_arbiter_if.master bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [5:0] TIMEOUT_C = 6'(TIMEOUT);

    logic [1:0] state_r;
    logic [5:0] wait_count_r;
    logic       last_grant_vga_r;
    logic       grant_vga_r;

    logic       grant_valid_s;
    logic       grant_vga_s;

    // Grant selection: a lone requester wins, a tie goes to whoever was not served last.
    always_comb begin
        grant_valid_s = bus.cpu_req | bus.vga_req;
        if (bus.cpu_req && bus.vga_req) begin
            grant_vga_s = ~last_grant_vga_r;
        end else if (bus.vga_req) begin
            grant_vga_s = 1'b1;
        end else begin
            grant_vga_s = 1'b0;
        end
    end

    // Transaction sequencer and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r               <= ST_IDLE;
            wait_count_r          <= 6'd0;
            last_grant_vga_r      <= 1'b1;
            grant_vga_r           <= 1'b0;
            bus.cpu_ack           <= 1'b0;
            bus.vga_ack           <= 1'b0;
            bus.cpu_read_data     <= 16'h0000;
            bus.dram_refresh_data <= 1'b0;
            bus.dram_addr         <= 25'd0;
            bus.dram_write_en     <= 1'b0;
            bus.dram_burst_en     <= 1'b0;
            bus.dram_data_in      <= 16'h0000;
            bus.timeout_err       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        state_r               <= ST_ISSUE;
                        grant_vga_r           <= grant_vga_s;
                        bus.dram_refresh_data <= 1'b1;
                        if (grant_vga_s) begin
                            // Line buffer region: bit 19 set, row, column group, 32-word aligned.
                            bus.dram_addr     <= {6'b000001, bus.vga_y_val, bus.vga_x_group, 5'b00000};
                            bus.dram_write_en <= 1'b0;
                            bus.dram_burst_en <= 1'b1;
                        end else begin
                            bus.dram_addr     <= {9'b000000000, bus.cpu_addr};
                            bus.dram_write_en <= bus.cpu_write_en;
                            bus.dram_burst_en <= 1'b0;
                            bus.dram_data_in  <= bus.cpu_data_in;
                        end
                    end
                end
                ST_ISSUE: begin
                    // Ready seen here belongs to no request of ours, so it is ignored.
                    bus.dram_refresh_data <= 1'b0;
                    wait_count_r          <= 6'd0;
                    state_r               <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.dram_data_ready || (wait_count_r == TIMEOUT_C)) begin
                        state_r <= ST_DONE;
                        if (!bus.dram_data_ready) begin
                            bus.timeout_err <= 1'b1;
                        end
                        if (grant_vga_r) begin
                            bus.vga_ack <= 1'b1;
                        end else begin
                            bus.cpu_ack <= 1'b1;
                            if (!bus.dram_write_en) begin
                                bus.cpu_read_data <= bus.dram_data_ready ? bus.dram_read_data : 16'hFFFF;
                            end
                        end
                    end else begin
                        wait_count_r <= wait_count_r + 6'd1;
                    end
                end
                ST_DONE: begin
                    bus.cpu_ack      <= 1'b0;
                    bus.vga_ack      <= 1'b0;
                    last_grant_vga_r <= grant_vga_r;
                    state_r          <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Randomized bench for dram_arbiter: a transaction-timeline model predicts every output each cycle.
// Requesters and a DRAM controller stand-in are driven from the same loop that runs the model.
module tb_dram_arbiter;

    localparam int T = 4;
    localparam int N_CYCLES = 4000;

    logic clk;
    logic rst;

    dram_arbiter_if bus ();

    dram_arbiter #(.TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // Reference model state: a transaction is described by its grant owner and its timeline.
    bit          busy;
    int          phase;       // 1 = strobe cycle, 2.. = waiting, ack_phase = completion cycle
    int          ack_phase;
    int          ready_at;    // waiting-cycle index at which the controller answers
    bit          tmo;
    bit          own_vga;
    bit          last_vga;
    logic [24:0] exp_addr;
    logic        exp_we;
    logic        exp_burst;
    logic [15:0] exp_din;
    logic [15:0] exp_rd;
    logic        exp_err;

    bit          cpu_pend;
    bit          vga_pend;
    int          cpu_rate;
    int          vga_rate;
    bit          want_rst;
    bit          rst_now;
    bit          exp_strobe;
    bit          exp_cack;
    bit          exp_vack;
    logic [15:0] rd_drv;
    int          cpu_acks;
    int          vga_acks;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        busy      = 1'b0;
        phase     = 0;
        ack_phase = 0;
        last_vga  = 1'b1;
        exp_addr  = 25'd0;
        exp_we    = 1'b0;
        exp_burst = 1'b0;
        exp_din   = 16'h0000;
        exp_rd    = 16'h0000;
        exp_err   = 1'b0;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        cpu_pend = 1'b0;
        vga_pend = 1'b0;
        cpu_rate = 100;
        vga_rate = 100;
        want_rst = 1'b0;
        cpu_acks = 0;
        vga_acks = 0;
        own_vga  = 1'b0;
        tmo      = 1'b0;
        ready_at = 0;
        model_reset();

        rst                  = 1'b1;
        bus.cpu_req          = 1'b0;
        bus.cpu_addr         = 16'h0000;
        bus.cpu_write_en     = 1'b0;
        bus.cpu_data_in      = 16'h0000;
        bus.vga_req          = 1'b0;
        bus.vga_y_val        = 9'd0;
        bus.vga_x_group      = 5'd0;
        bus.dram_read_data   = 16'h0000;
        bus.dram_data_ready  = 1'b0;

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge clk);

            // Compare this cycle's outputs against the model.
            exp_strobe = busy && (phase == 1);
            exp_cack   = busy && (phase == ack_phase) && !own_vga;
            exp_vack   = busy && (phase == ack_phase) && own_vga;
            check_eq("strobe",   32'(bus.dram_refresh_data), 32'(exp_strobe));
            check_eq("cpu_ack",  32'(bus.cpu_ack),           32'(exp_cack));
            check_eq("vga_ack",  32'(bus.vga_ack),           32'(exp_vack));
            check_eq("addr",     32'(bus.dram_addr),         32'(exp_addr));
            check_eq("write_en", 32'(bus.dram_write_en),     32'(exp_we));
            check_eq("burst_en", 32'(bus.dram_burst_en),     32'(exp_burst));
            check_eq("rd_data",  32'(bus.cpu_read_data),     32'(exp_rd));
            check_eq("tmo_err",  32'(bus.timeout_err),       32'(exp_err));
            if (busy && !own_vga) begin
                check_eq("data_in", 32'(bus.dram_data_in), 32'(exp_din));
            end
            if (exp_cack) cpu_acks++;
            if (exp_vack) vga_acks++;

            // Requesters drop req on the edge that samples their ack, then may request again.
            if (exp_cack) cpu_pend = 1'b0;
            if (exp_vack) vga_pend = 1'b0;
            if (cyc >= 80 && (cyc % 200) == 0) begin
                cpu_rate = $urandom_range(10, 100);
                vga_rate = $urandom_range(10, 100);
            end
            if (!cpu_pend && ($urandom_range(0, 99) < cpu_rate)) cpu_pend = 1'b1;
            if (!vga_pend && ($urandom_range(0, 99) < vga_rate)) vga_pend = 1'b1;

            // Request payloads churn every cycle; only the grant-cycle values may matter.
            bus.cpu_req        = cpu_pend;
            bus.vga_req        = vga_pend;
            bus.cpu_addr       = 16'($urandom);
            bus.cpu_write_en   = 1'($urandom);
            bus.cpu_data_in    = 16'($urandom);
            bus.vga_y_val      = 9'($urandom);
            bus.vga_x_group    = 5'($urandom);
            rd_drv             = 16'($urandom);
            bus.dram_read_data = rd_drv;
            if (busy && phase >= 2 && phase < ack_phase) begin
                bus.dram_data_ready = ((phase - 2) == ready_at);
            end else begin
                bus.dram_data_ready = 1'($urandom);
            end

            if (cyc == 500 || cyc == 2100) want_rst = 1'b1;
            rst_now = (cyc < 3) || ($urandom_range(0, 249) == 0);
            if (want_rst && busy && phase >= 2 && phase < ack_phase) begin
                rst_now  = 1'b1;
                want_rst = 1'b0;
            end
            rst = rst_now;

            // Advance the model to the next cycle.
            if (rst_now) begin
                model_reset();
            end else if (!busy) begin
                if (bus.cpu_req || bus.vga_req) begin
                    own_vga = (bus.cpu_req && bus.vga_req) ? !last_vga : bus.vga_req;
                    if (own_vga) begin
                        exp_addr  = 25'(32'h80000 + 32'(bus.vga_y_val) * 32'd1024 + 32'(bus.vga_x_group) * 32'd32);
                        exp_we    = 1'b0;
                        exp_burst = 1'b1;
                    end else begin
                        exp_addr  = 25'(bus.cpu_addr);
                        exp_we    = bus.cpu_write_en;
                        exp_burst = 1'b0;
                        exp_din   = bus.cpu_data_in;
                    end
                    ready_at  = $urandom_range(0, T + 2);
                    tmo       = (ready_at > T);
                    ack_phase = (tmo ? T : ready_at) + 3;
                    busy      = 1'b1;
                    phase     = 1;
                end
            end else if (phase == ack_phase) begin
                busy = 1'b0;
            end else begin
                if (phase == ack_phase - 1) begin
                    if (tmo) exp_err = 1'b1;
                    if (!own_vga && !exp_we) exp_rd = tmo ? 16'hFFFF : rd_drv;
                    last_vga = own_vga;
                end
                phase++;
            end
        end

        // The run must have exercised both requesters.
        check_eq("cpu_served", 32'(cpu_acks > 20), 32'd1);
        check_eq("vga_served", 32'(vga_acks > 20), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
